// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if.sv
// gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if: request, ack and status bundle between a power controller and the switch sequencer
interface gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if #(
  parameter int NSEG = 8,
  parameter int SETTLE_W = 8
);
  logic pwr_req;
  logic [SETTLE_W-1:0] settle;
  logic sw_ack;
  logic [NSEG-1:0] sw_en;
  logic iso_n;
  logic pwr_good;
  logic busy;
  logic err;
  modport master (output pwr_req, settle, sw_ack, input sw_en, iso_n, pwr_good, busy, err);
  modport slave (input pwr_req, settle, sw_ack, output sw_en, iso_n, pwr_good, busy, err);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq: staggered header-switch enable sequencer with isolation release; GF180_PWRSW_SEQ_TIMEOUT_EN adds a sticky ack timeout
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(
  parameter int NSEG = 8,
  parameter int SETTLE_W = 8,
  parameter int TO_W = 10
) (
  input logic clk,
  input logic rst,
  gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_if.slave bus,
  inout wire vdd,
  inout wire vss
);
  typedef enum logic [2:0] {OFF, RAMP_UP, WAIT_ACK, ON, ISO, RAMP_DOWN} state_t;
  state_t st, st_n;
  logic [SETTLE_W-1:0] cnt, cnt_n;
  logic [NSEG-1:0] sw_en, sw_en_n;
  logic err, err_n, to_hit;
  logic unused;
  assign unused = ^{vdd, vss};
  assign bus.sw_en = sw_en;
  assign bus.err = err;
`ifdef GF180_PWRSW_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  // ack wait counter, held at zero outside WAIT_ACK so it restarts on every entry
  always_ff @(posedge clk)
    to_cnt <= (rst || st != WAIT_ACK) ? '0 : to_cnt + 1'b1;
  assign to_hit = (st == WAIT_ACK) && (&to_cnt) && !bus.sw_ack;
`else
  logic [TO_W-1:0] unused_to;
  assign unused_to = '0;
  assign to_hit = 1'b0;
`endif
  // next state; abort on request drop always wins over the settle count and ack
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    sw_en_n = sw_en;
    err_n = err;
    case (st)
      OFF:
        if (bus.pwr_req) begin
          st_n = RAMP_UP;
          sw_en_n = NSEG'(1);
          cnt_n = bus.settle;
          err_n = 1'b0;
        end
      RAMP_UP:
        if (!bus.pwr_req) begin
          st_n = RAMP_DOWN;
          cnt_n = bus.settle;
        end else if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (&sw_en) st_n = WAIT_ACK;
        else begin
          sw_en_n = {sw_en[NSEG-2:0], 1'b1};
          cnt_n = bus.settle;
        end
      WAIT_ACK:
        if (!bus.pwr_req || to_hit) begin
          st_n = RAMP_DOWN;
          cnt_n = bus.settle;
          err_n = err | to_hit;
        end else if (bus.sw_ack) st_n = ON;
      ON:
        if (!bus.pwr_req) begin
          st_n = ISO;
          cnt_n = bus.settle;
        end
      ISO:
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          st_n = RAMP_DOWN;
          sw_en_n = sw_en >> 1;
          cnt_n = bus.settle;
        end
      RAMP_DOWN:
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else begin
          sw_en_n = sw_en >> 1;
          cnt_n = bus.settle;
          st_n = (sw_en[NSEG-1:1] == '0) ? OFF : RAMP_DOWN;
        end
      default: st_n = OFF;
    endcase
  end
  // state and registered outputs, decoded from the next state so nothing is combinational to the pins
  always_ff @(posedge clk)
    if (rst) begin
      st <= OFF;
      cnt <= '0;
      sw_en <= '0;
      err <= 1'b0;
      bus.iso_n <= 1'b0;
      bus.pwr_good <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      sw_en <= sw_en_n;
      err <= err_n;
      bus.iso_n <= st_n == ON;
      bus.pwr_good <= st_n == ON;
      bus.busy <= st_n != OFF && st_n != ON;
    end
endmodule
